// File: rtl/usb_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_pkg
// Brief    : RX status codes, FSM state type and CRC constants for the
//            USB receive data buffer.
// Revision : 1.0
// ============================================================================
package usb_rx_pkg;

   localparam logic [2:0] RX_NONE    = 3'd0;
   localparam logic [2:0] RX_OUT     = 3'd1;
   localparam logic [2:0] RX_IN      = 3'd2;
   localparam logic [2:0] RX_DATA    = 3'd3;
   localparam logic [2:0] RX_DATA_OK = 3'd4;
   localparam logic [2:0] RX_ACK     = 3'd5;
   localparam logic [2:0] RX_NAK     = 3'd6;
   localparam logic [2:0] RX_ERR     = 3'd7;

   localparam int CRC16_BYTES = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_BAD  = 2'd2
   } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/rx_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module   : rx_buffer_mem
// Brief    : DEPTH x 8 byte array, synchronous write, combinational read.
// Revision : 1.0
// ============================================================================
module rx_buffer_mem
   import usb_rx_pkg::*;
#(
   parameter int DEPTH = 128,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/usb_rx_data_buffer.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_data_buffer
// Brief    : Packet-aware RX FIFO; commits DATA payloads on good CRC16
//            (stripping the CRC bytes) and rolls back everything else.
// Revision : 1.0
// ============================================================================
module usb_rx_data_buffer
   import usb_rx_pkg::*;
#(
   parameter int DEPTH = 128
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic [2:0]              RX_packet,
   input  logic                    store_RX_packet_data,
   input  logic [7:0]              RX_packet_data,
   input  logic                    rd_en,
   input  logic                    flush,
   output logic [7:0]              rx_data,
   output logic                    rx_empty,
   output logic [$clog2(DEPTH):0]  rx_count,
   output logic                    pkt_ok,
   output logic                    pkt_drop,
   output logic                    overflow
);

   localparam int            AW        = $clog2(DEPTH);
   localparam int            PW        = AW + 1;
   localparam logic [PW-1:0] FULL_FILL = PW'(DEPTH);
   localparam logic [PW-1:0] CRC_LEN   = PW'(CRC16_BYTES);

   rx_state_e     state_q;
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] cptr_q;
   logic [PW-1:0] rptr_q;
   logic          pkt_ok_q;
   logic          pkt_drop_q;
   logic          overflow_q;

   logic [PW-1:0] pending;
   logic          full;
   logic          is_data;
   logic          rd_fire;
   logic          wr_fire;
   logic [7:0]    mem_rdata;

   // Fullness counts tentative bytes against the reader, so unread data limits capacity.
   assign full     = (wptr_q - rptr_q) == FULL_FILL;
   assign pending  = wptr_q - cptr_q;
   assign is_data  = (RX_packet == RX_DATA);
   assign rx_empty = (cptr_q == rptr_q);
   assign rx_count = cptr_q - rptr_q;
   assign rd_fire  = rd_en && !rx_empty;
   assign wr_fire  = !flush && (state_q == ST_RECV) && is_data && store_RX_packet_data && !full;

   assign rx_data  = rx_empty ? 8'h00 : mem_rdata;
   assign pkt_ok   = pkt_ok_q;
   assign pkt_drop = pkt_drop_q;
   assign overflow = overflow_q;

   rx_buffer_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_fire),
      .waddr_i (wptr_q[AW-1:0]),
      .wdata_i (RX_packet_data),
      .raddr_i (rptr_q[AW-1:0]),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= ST_IDLE;
         wptr_q     <= '0;
         cptr_q     <= '0;
         rptr_q     <= '0;
         pkt_ok_q   <= 1'b0;
         pkt_drop_q <= 1'b0;
         overflow_q <= 1'b0;
      end else if (flush) begin
         state_q    <= ST_IDLE;
         wptr_q     <= '0;
         cptr_q     <= '0;
         rptr_q     <= '0;
         pkt_ok_q   <= 1'b0;
         pkt_drop_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         pkt_ok_q   <= 1'b0;
         pkt_drop_q <= 1'b0;
         if (rd_fire) begin
            rptr_q <= rptr_q + 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (is_data) begin
                  state_q <= ST_RECV;
               end
            end
            ST_RECV: begin
               if (RX_packet == RX_DATA_OK) begin
                  state_q <= ST_IDLE;
                  if (pending >= CRC_LEN) begin
                     cptr_q   <= wptr_q - CRC_LEN;
                     wptr_q   <= wptr_q - CRC_LEN;
                     pkt_ok_q <= 1'b1;
                  end else begin
                     wptr_q     <= cptr_q;
                     pkt_drop_q <= 1'b1;
                  end
               end else if (!is_data) begin
                  state_q    <= ST_IDLE;
                  wptr_q     <= cptr_q;
                  pkt_drop_q <= 1'b1;
               end else if (store_RX_packet_data) begin
                  if (full) begin
                     overflow_q <= 1'b1;
                     state_q    <= ST_BAD;
                  end else begin
                     wptr_q <= wptr_q + 1'b1;
                  end
               end
            end
            ST_BAD: begin
               if (!is_data) begin
                  state_q    <= ST_IDLE;
                  wptr_q     <= cptr_q;
                  pkt_drop_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_data_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_rx_data_buffer
// Brief    : Directed bench with a queue-based packet model for the buffer.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_usb_rx_data_buffer;
   import usb_rx_pkg::*;

   localparam int DEPTH = 128;
   localparam int PW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic [2:0]    RX_packet = RX_NONE;
   logic          store_RX_packet_data = 1'b0;
   logic [7:0]    RX_packet_data = 8'h00;
   logic          rd_en = 1'b0;
   logic          flush = 1'b0;
   logic [7:0]    rx_data;
   logic          rx_empty;
   logic [PW-1:0] rx_count;
   logic          pkt_ok;
   logic          pkt_drop;
   logic          overflow;

   int n_checks = 0;
   int n_err    = 0;

   // Model: committed bytes, tentative bytes, mode 0=idle 1=receiving 2=discarding.
   logic [7:0] cq[$];
   logic [7:0] tq[$];
   int         m_mode = 0;
   bit         m_ovf  = 1'b0;
   bit         m_ok   = 1'b0;
   bit         m_drop = 1'b0;

   usb_rx_data_buffer #(.DEPTH(DEPTH)) dut (
      .clk                  (clk),
      .n_rst                (n_rst),
      .RX_packet            (RX_packet),
      .store_RX_packet_data (store_RX_packet_data),
      .RX_packet_data       (RX_packet_data),
      .rd_en                (rd_en),
      .flush                (flush),
      .rx_data              (rx_data),
      .rx_empty             (rx_empty),
      .rx_count             (rx_count),
      .pkt_ok               (pkt_ok),
      .pkt_drop             (pkt_drop),
      .overflow             (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      cq.delete();
      tq.delete();
      m_mode = 0;
      m_ovf  = 1'b0;
      m_ok   = 1'b0;
      m_drop = 1'b0;
   endtask

   task automatic model_step();
      bit rd;
      int occ;
      m_ok   = 1'b0;
      m_drop = 1'b0;
      if (flush) begin
         model_clear();
      end else begin
         rd  = rd_en && (cq.size() != 0);
         occ = cq.size() + tq.size();
         case (m_mode)
            0: if (RX_packet == RX_DATA) m_mode = 1;
            1: begin
               if (RX_packet == RX_DATA_OK) begin
                  if (tq.size() >= 2) begin
                     for (int i = 0; i < tq.size() - 2; i++) cq.push_back(tq[i]);
                     m_ok = 1'b1;
                  end else begin
                     m_drop = 1'b1;
                  end
                  tq.delete();
                  m_mode = 0;
               end else if (RX_packet != RX_DATA) begin
                  tq.delete();
                  m_drop = 1'b1;
                  m_mode = 0;
               end else if (store_RX_packet_data) begin
                  if (occ >= DEPTH) begin
                     m_ovf  = 1'b1;
                     m_mode = 2;
                  end else begin
                     tq.push_back(RX_packet_data);
                  end
               end
            end
            default: begin
               if (RX_packet != RX_DATA) begin
                  tq.delete();
                  m_drop = 1'b1;
                  m_mode = 0;
               end
            end
         endcase
         if (rd) void'(cq.pop_front());
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge n_rst);
         if (!n_rst) model_clear();
         else        model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check("rx_empty", {31'd0, rx_empty}, {31'd0, cq.size() == 0});
         check("rx_count", 32'(rx_count), 32'(cq.size()));
         check("pkt_ok", {31'd0, pkt_ok}, {31'd0, m_ok});
         check("pkt_drop", {31'd0, pkt_drop}, {31'd0, m_drop});
         check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
         check("count_le_depth", {31'd0, 32'(rx_count) <= DEPTH}, 32'd1);
         if (cq.size() != 0) check("rx_data", 32'(rx_data), 32'(cq[0]));
      end
   end

   task automatic step(input logic [2:0] code, input logic stb, input logic [7:0] d,
                       input logic rd, input logic fl);
      RX_packet            = code;
      store_RX_packet_data = stb;
      RX_packet_data       = d;
      rd_en                = rd;
      flush                = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input int n, input int base, input logic [2:0] endc);
      step(RX_DATA, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) step(RX_DATA, 1'b1, 8'(base + i), 1'b0, 1'b0);
      step(endc, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int k = 0; k < DEPTH + 4; k++) begin
         if (rx_empty) break;
         step(RX_NONE, 1'b0, 8'h00, 1'b1, 1'b0);
      end
      check("drain_empty", {31'd0, rx_empty}, 32'd1);
   endtask

   initial begin
      logic [7:0] t1 [5];
      t1 = '{8'h11, 8'h22, 8'h33, 8'hAA, 8'hBB};

      repeat (2) step(RX_NONE, 1'b0, 8'h00, 1'b0, 1'b0);
      check("rst_empty", {31'd0, rx_empty}, 32'd1);
      check("rst_count", 32'(rx_count), 32'd0);
      check("rst_data", 32'(rx_data), 32'd0);
      check("rst_ok", {31'd0, pkt_ok}, 32'd0);
      check("rst_drop", {31'd0, pkt_drop}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      n_rst = 1'b1;
      step(RX_NONE, 1'b0, 8'h00, 1'b0, 1'b0);

      // Good packet; the last two bytes are CRC and must not appear.
      step(RX_DATA, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(RX_DATA, 1'b1, t1[i], 1'b0, 1'b0);
      step(RX_DATA_OK, 1'b0, 8'h00, 1'b0, 1'b0);
      check("good_ok", {31'd0, pkt_ok}, 32'd1);
      check("good_count", 32'(rx_count), 32'd3);
      check("good_d0", 32'(rx_data), 32'h11);
      step(RX_NONE, 1'b1, 8'h5A, 1'b0, 1'b0);
      check("good_ok_one_cycle", {31'd0, pkt_ok}, 32'd0);
      step(RX_NONE, 1'b0, 8'h00, 1'b1, 1'b0);
      check("good_d1", 32'(rx_data), 32'h22);
      step(RX_NONE, 1'b0, 8'h00, 1'b1, 1'b0);
      check("good_d2", 32'(rx_data), 32'h33);
      step(RX_NONE, 1'b0, 8'h00, 1'b1, 1'b0);
      check("good_empty", {31'd0, rx_empty}, 32'd1);

      // CRC failure and short packets leave committed data alone.
      send_pkt(4, 'hA1, RX_DATA_OK);
      check("pre_count", 32'(rx_count), 32'd2);
      send_pkt(4, 'h50, RX_ERR);
      check("crcfail_drop", {31'd0, pkt_drop}, 32'd1);
      check("crcfail_count", 32'(rx_count), 32'd2);
      check("crcfail_data", 32'(rx_data), 32'hA1);
      send_pkt(1, 'h60, RX_DATA_OK);
      check("short_drop", {31'd0, pkt_drop}, 32'd1);
      send_pkt(2, 'h70, RX_DATA_OK);
      check("crc_only_ok", {31'd0, pkt_ok}, 32'd1);
      check("crc_only_count", 32'(rx_count), 32'd2);
      drain();

      // Overflow against 100 unread committed bytes.
      send_pkt(102, 0, RX_DATA_OK);
      check("ovf_pre_count", 32'(rx_count), 32'd100);
      send_pkt(40, 'h80, RX_DATA_OK);
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      check("ovf_drop", {31'd0, pkt_drop}, 32'd1);
      check("ovf_count", 32'(rx_count), 32'd100);
      check("ovf_data", 32'(rx_data), 32'h00);
      step(RX_NONE, 1'b0, 8'h00, 1'b0, 1'b1);
      check("flush_ovf", {31'd0, overflow}, 32'd0);
      check("flush_count", 32'(rx_count), 32'd0);

      // Reads overlapping reception and commit.
      send_pkt(7, 'h10, RX_DATA_OK);
      step(RX_DATA, 1'b0, 8'h00, 1'b0, 1'b0);
      step(RX_DATA, 1'b1, 8'h20, 1'b1, 1'b0);
      for (int i = 1; i < 5; i++) step(RX_DATA, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      step(RX_DATA_OK, 1'b0, 8'h00, 1'b0, 1'b0);
      check("conc_count7", 32'(rx_count), 32'd7);
      step(RX_DATA, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(RX_DATA, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      step(RX_DATA_OK, 1'b0, 8'h00, 1'b1, 1'b0);
      check("conc_count8", 32'(rx_count), 32'd8);
      check("conc_data", 32'(rx_data), 32'h12);
      drain();

      // Flush and reset in the middle of a packet.
      step(RX_DATA, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(RX_DATA, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      step(RX_DATA, 1'b0, 8'h00, 1'b0, 1'b1);
      check("midflush_empty", {31'd0, rx_empty}, 32'd1);
      check("midflush_drop", {31'd0, pkt_drop}, 32'd0);
      send_pkt(5, 'h90, RX_DATA_OK);
      check("postflush_count", 32'(rx_count), 32'd3);
      step(RX_DATA, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(RX_DATA, 1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
      n_rst = 1'b0;
      #1;
      check("midrst_empty", {31'd0, rx_empty}, 32'd1);
      check("midrst_count", 32'(rx_count), 32'd0);
      step(RX_NONE, 1'b0, 8'h00, 1'b0, 1'b0);
      n_rst = 1'b1;
      step(RX_NONE, 1'b0, 8'h00, 1'b0, 1'b0);
      send_pkt(4, 'hC0, RX_DATA_OK);
      check("postrst_count", 32'(rx_count), 32'd2);
      check("postrst_data", 32'(rx_data), 32'hC0);
      drain();

      // Ten 62-byte payloads carry the pointers across several wraps.
      for (int p = 0; p < 10; p++) begin
         send_pkt(64, p * 13, RX_DATA_OK);
         check("wrap_count", 32'(rx_count), 32'd62);
         drain();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
